mult_sequencer: RTL

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/mult_sequencer.sv
// Control sequencer for an 8x8 signed shift-add multiplier.
// Steers an external {X,A,B} register unit through load and shift steps.
module mult_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        ClearA_LoadB,
  input  logic [7:0]  S,
  input  logic [15:0] Reg_Data,
  input  logic        Reg_X,
  output logic        Load,
  output logic        Shift_En,
  output logic [8:0]  A_Load,
  output logic [7:0]  B_Load,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    IDLE,
    CLRA,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [8:0] a9, s9, sum;
  logic       unused_x;

  // X is status only; the new sign always comes from the 9-bit sum
  assign unused_x = Reg_X;

  assign a9  = {Reg_Data[15], Reg_Data[15:8]};
  assign s9  = {S[7], S};
  assign sum = (cnt_q == 3'd7) ? (a9 - s9) : (a9 + s9);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Load     = 1'b0;
    Shift_En = 1'b0;
    A_Load   = '0;
    B_Load   = '0;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = CLRA;
          cnt_d   = '0;
        end else if (ClearA_LoadB) begin
          Load   = 1'b1;
          B_Load = S;
        end
      end
      CLRA: begin
        Busy    = 1'b1;
        Load    = 1'b1;
        B_Load  = Reg_Data[7:0];
        state_d = ADD;
      end
      ADD: begin
        Busy    = 1'b1;
        state_d = SHIFT;
        if (Reg_Data[0]) begin
          Load   = 1'b1;
          A_Load = sum;
          B_Load = Reg_Data[7:0];
        end
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
